// File: rtl/pipe_slice_pkg.sv
// pipe_slice_pkg
// Shared types and helpers for the pipe_slice valid/ready pipeline slice.
//   slice_mode_e : elaboration-time timing mode (PASS, FWD, BWD, FIFO)
//   clog2_cnt()  : width of a counter that must hold 0..depth inclusive
//   STALL_CNT_W  : width of the optional downstream stall counter
package pipe_slice_pkg;

  typedef enum logic [1:0] {
    SLICE_PASS,
    SLICE_FWD,
    SLICE_BWD,
    SLICE_FIFO
  } slice_mode_e;

  localparam int STALL_CNT_W = 32;

  // An occupancy counter must represent "full" (depth) as well as zero,
  // hence depth+1 distinct values.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_slice_fifo_core.sv
// pipe_slice_fifo_core
// Circular-buffer FIFO used by pipe_slice in FIFO mode.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : synchronous discard of all stored beats
//   s_data/s_valid/s_ready : upstream stream (s_ready registered: !full)
//   m_data/m_valid/m_ready : downstream stream (m_valid registered: !empty)
//   occupancy           : number of stored beats
//   almost_full         : occupancy >= AF_THRESH
module pipe_slice_fifo_core
  import pipe_slice_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2,
  parameter int AF_THRESH  = DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [clog2_cnt(DEPTH)-1:0]   occupancy,
  output logic                          almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = clog2_cnt(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  full_q;
  logic                  nonempty_q;
  logic                  push;
  logic                  pop;

  // Explicit wrap compare so non-power-of-two depths never index past the end.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // Both handshake flags come straight from flops; reset and flush block all transfers.
  assign s_ready = ~full_q & ~rst & ~flush;
  assign m_valid = nonempty_q & ~rst & ~flush;
  assign m_data  = mem[rd_ptr];
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Storage, pointers and registered full/non-empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      nonempty_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      nonempty_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count      <= count_next;
      full_q     <= (count_next == FULL_CNT);
      nonempty_q <= (count_next != '0);
    end
  end

  assign occupancy   = count;
  assign almost_full = (count >= CNT_W'(AF_THRESH));

endmodule

// File: rtl/pipe_slice.sv
// pipe_slice
// Parametrised valid/ready pipeline slice: pass-through, forward-registered,
// backward-registered (skid) or DEPTH-entry FIFO, chosen by MODE.
// Optional macro PIPE_SLICE_STALL_CNT_EN adds a saturating stall_cnt output.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   flush                  : synchronous discard of all stored beats
//   s_data/s_valid/s_ready : upstream stream
//   m_data/m_valid/m_ready : downstream stream
//   occupancy              : stored beats (always 0 in PASS mode)
//   almost_full            : occupancy >= AF_THRESH
//   stall_cnt              : (macro only) cycles with m_valid & !m_ready
module pipe_slice
  import pipe_slice_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MODE       = 3,
  parameter int DEPTH      = 2,
  parameter int AF_THRESH  = DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [clog2_cnt(DEPTH)-1:0]   occupancy,
  output logic                          almost_full
`ifdef PIPE_SLICE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]        stall_cnt
`endif
);

  localparam int OCC_W = clog2_cnt(DEPTH);
  localparam slice_mode_e MODE_E = slice_mode_e'(MODE[1:0]);

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("pipe_slice: illegal MODE %0d", MODE);
  end
  if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
    $error("pipe_slice: illegal DEPTH %0d", DEPTH);
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("pipe_slice: illegal AF_THRESH %0d", AF_THRESH);
  end

  if (MODE_E == SLICE_PASS) begin : g_pass
    // Pure wires; flush and reset simply block the handshake on both sides.
    assign m_data      = s_data;
    assign m_valid     = s_valid & ~flush & ~rst;
    assign s_ready     = m_ready & ~flush & ~rst;
    assign occupancy   = '0;
    assign almost_full = 1'b0;

  end else if (MODE_E == SLICE_FWD) begin : g_fwd
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  accept;

    // Ready looks through to m_ready so a full register still streams 1 beat/cycle.
    assign s_ready = ~rst & ~flush & (~out_valid | m_ready);
    assign accept  = s_valid & s_ready;

    // Output register: load on accept, otherwise drain when downstream takes it.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end else if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= s_data;
      end else if (m_ready) begin
        out_valid <= 1'b0;
      end
    end

    assign m_valid     = out_valid & ~flush & ~rst;
    assign m_data      = out_data;
    assign occupancy   = OCC_W'(out_valid);
    assign almost_full = (occupancy >= OCC_W'(AF_THRESH));

  end else if (MODE_E == SLICE_BWD) begin : g_bwd
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;

    // Ready depends only on the skid flop, cutting the m_ready -> s_ready path.
    assign s_ready = ~skid_valid & ~rst & ~flush;
    // The pass-through path is only offered while upstream can actually hand over.
    assign m_valid = ~rst & ~flush & (skid_valid | s_valid);
    assign m_data  = skid_valid ? skid_data : s_data;

    // Skid register catches a beat accepted upstream but refused downstream.
    always_ff @(posedge clk) begin
      if (rst) begin
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end else if (flush) begin
        skid_valid <= 1'b0;
      end else if (skid_valid) begin
        if (m_ready) begin
          skid_valid <= 1'b0;
        end
      end else if (s_valid && !m_ready) begin
        skid_valid <= 1'b1;
        skid_data  <= s_data;
      end
    end

    assign occupancy   = OCC_W'(skid_valid);
    assign almost_full = (occupancy >= OCC_W'(AF_THRESH));

  end else begin : g_fifo
    pipe_slice_fifo_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AF_THRESH  (AF_THRESH)
    ) u_core (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .occupancy   (occupancy),
      .almost_full (almost_full)
    );
  end

`ifdef PIPE_SLICE_STALL_CNT_EN
  // Saturating count of cycles where downstream holds off a valid beat.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_slice.sv
// tb_pipe_slice
// Directed bench for pipe_slice: one instance per mode (PASS, FWD, BWD,
// FIFO with DEPTH=3/AF_THRESH=2) sharing clk, rst and flush.
// Honours PIPE_SLICE_STALL_CNT_EN when defined.
module tb_pipe_slice;

  localparam int DW = 16;

  logic clk;
  logic rst;
  logic flush;

  logic [DW-1:0] s_data_pass, m_data_pass, s_data_fwd, m_data_fwd;
  logic [DW-1:0] s_data_bwd, m_data_bwd, s_data_fifo, m_data_fifo;
  logic s_valid_pass, s_ready_pass, m_valid_pass, m_ready_pass, af_pass;
  logic s_valid_fwd, s_ready_fwd, m_valid_fwd, m_ready_fwd, af_fwd;
  logic s_valid_bwd, s_ready_bwd, m_valid_bwd, m_ready_bwd, af_bwd;
  logic s_valid_fifo, s_ready_fifo, m_valid_fifo, m_ready_fifo, af_fifo;
  logic [1:0] occ_pass, occ_fwd, occ_bwd;
  logic [2:0] occ_fifo;
`ifdef PIPE_SLICE_STALL_CNT_EN
  logic [31:0] stall_pass, stall_fwd, stall_bwd, stall_fifo;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          flsh;
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_ready;
  } pass_vec_t;

  pass_vec_t pass_vecs [5];

  pipe_slice #(.DATA_WIDTH(DW), .MODE(0)) u_pass (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data_pass), .s_valid(s_valid_pass), .s_ready(s_ready_pass),
    .m_data(m_data_pass), .m_valid(m_valid_pass), .m_ready(m_ready_pass),
    .occupancy(occ_pass), .almost_full(af_pass)
`ifdef PIPE_SLICE_STALL_CNT_EN
    , .stall_cnt(stall_pass)
`endif
  );

  pipe_slice #(.DATA_WIDTH(DW), .MODE(1)) u_fwd (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data_fwd), .s_valid(s_valid_fwd), .s_ready(s_ready_fwd),
    .m_data(m_data_fwd), .m_valid(m_valid_fwd), .m_ready(m_ready_fwd),
    .occupancy(occ_fwd), .almost_full(af_fwd)
`ifdef PIPE_SLICE_STALL_CNT_EN
    , .stall_cnt(stall_fwd)
`endif
  );

  pipe_slice #(.DATA_WIDTH(DW), .MODE(2)) u_bwd (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data_bwd), .s_valid(s_valid_bwd), .s_ready(s_ready_bwd),
    .m_data(m_data_bwd), .m_valid(m_valid_bwd), .m_ready(m_ready_bwd),
    .occupancy(occ_bwd), .almost_full(af_bwd)
`ifdef PIPE_SLICE_STALL_CNT_EN
    , .stall_cnt(stall_bwd)
`endif
  );

  pipe_slice #(.DATA_WIDTH(DW), .MODE(3), .DEPTH(3), .AF_THRESH(2)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data_fifo), .s_valid(s_valid_fifo), .s_ready(s_ready_fifo),
    .m_data(m_data_fifo), .m_valid(m_valid_fifo), .m_ready(m_ready_fifo),
    .occupancy(occ_fifo), .almost_full(af_fifo)
`ifdef PIPE_SLICE_STALL_CNT_EN
    , .stall_cnt(stall_fifo)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Runaway guard so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison; every check in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one PASS-mode vector and let the combinational paths settle.
  task automatic applyStimulus(input pass_vec_t v);
    s_data_pass  = v.data;
    s_valid_pass = v.valid;
    m_ready_pass = v.ready;
    flush        = v.flsh;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Occupancy of the 3-deep FIFO must never exceed 3 (a wrapped counter would).
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("fifo_occ_bound", 64'(occ_fifo > 3'd3), 64'd0);
    end
  end

  initial begin
    pass_vecs[0] = '{16'h1234, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b1};
    pass_vecs[1] = '{16'hABCD, 1'b0, 1'b1, 1'b0, 16'hABCD, 1'b0, 1'b1};
    pass_vecs[2] = '{16'h5555, 1'b1, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b0};
    pass_vecs[3] = '{16'h0F0F, 1'b1, 1'b1, 1'b1, 16'h0F0F, 1'b0, 1'b0};
    pass_vecs[4] = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    rst = 1'b1;
    flush = 1'b0;
    s_data_pass = '0; s_valid_pass = 1'b0; m_ready_pass = 1'b0;
    s_data_fwd  = '0; s_valid_fwd  = 1'b0; m_ready_fwd  = 1'b0;
    s_data_bwd  = '0; s_valid_bwd  = 1'b0; m_ready_bwd  = 1'b0;
    s_data_fifo = '0; s_valid_fifo = 1'b0; m_ready_fifo = 1'b0;

    // Reset: ready held low while rst is high, clean state afterwards.
    tick();
    tick();
    checkOutput("rst_s_ready_fwd", s_ready_fwd, 0);
    checkOutput("rst_s_ready_bwd", s_ready_bwd, 0);
    checkOutput("rst_s_ready_fifo", s_ready_fifo, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_s_ready_fwd", s_ready_fwd, 1);
    checkOutput("post_rst_s_ready_bwd", s_ready_bwd, 1);
    checkOutput("post_rst_s_ready_fifo", s_ready_fifo, 1);
    checkOutput("post_rst_m_valid_fwd", m_valid_fwd, 0);
    checkOutput("post_rst_m_valid_fifo", m_valid_fifo, 0);
    checkOutput("post_rst_occ_fifo", occ_fifo, 0);
    checkOutput("post_rst_af_fifo", af_fifo, 0);
    checkOutput("post_rst_af_fwd", af_fwd, 0);

    // PASS mode table.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(pass_vecs[i]);
      checkOutput($sformatf("pass_m_data[%0d]", i), m_data_pass, pass_vecs[i].exp_data);
      checkOutput($sformatf("pass_m_valid[%0d]", i), m_valid_pass, pass_vecs[i].exp_valid);
      checkOutput($sformatf("pass_s_ready[%0d]", i), s_ready_pass, pass_vecs[i].exp_ready);
      checkOutput($sformatf("pass_occ[%0d]", i), occ_pass, 0);
    end
    flush = 1'b0;
    tick();

    // FWD: continuous stream 0..9, one-cycle lag, no bubbles.
    m_ready_fwd = 1'b1;
    s_valid_fwd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data_fwd = DW'(i);
      #1;
      checkOutput($sformatf("fwd_s_ready[%0d]", i), s_ready_fwd, 1);
      if (i > 0) begin
        checkOutput($sformatf("fwd_m_valid[%0d]", i), m_valid_fwd, 1);
        checkOutput($sformatf("fwd_m_data[%0d]", i), m_data_fwd, 64'(i - 1));
      end
      tick();
    end
    s_valid_fwd = 1'b0;
    #1;
    checkOutput("fwd_last_m_valid", m_valid_fwd, 1);
    checkOutput("fwd_last_m_data", m_data_fwd, 9);
    tick();
    checkOutput("fwd_drained_m_valid", m_valid_fwd, 0);

    // FWD: held beat stays stable while stalled, then flush clears it.
    s_valid_fwd = 1'b1;
    s_data_fwd  = 16'h0077;
    m_ready_fwd = 1'b0;
    tick();
    s_valid_fwd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("fwd_stall_m_valid[%0d]", i), m_valid_fwd, 1);
      checkOutput($sformatf("fwd_stall_m_data[%0d]", i), m_data_fwd, 16'h0077);
      tick();
    end
`ifdef PIPE_SLICE_STALL_CNT_EN
    checkOutput("fwd_stall_cnt", stall_fwd, 5);
`endif
    flush = 1'b1;
    #1;
    checkOutput("fwd_flush_m_valid", m_valid_fwd, 0);
    checkOutput("fwd_flush_s_ready", s_ready_fwd, 0);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("fwd_post_flush_m_valid", m_valid_fwd, 0);
    checkOutput("fwd_post_flush_occ", occ_fwd, 0);
`ifdef PIPE_SLICE_STALL_CNT_EN
    checkOutput("fwd_post_flush_stall_cnt", stall_fwd, 0);
`endif

    // BWD: beat 0xA refused downstream lands in the skid.
    s_valid_bwd = 1'b1;
    s_data_bwd  = 16'h000A;
    m_ready_bwd = 1'b0;
    #1;
    checkOutput("bwd_pass_m_valid", m_valid_bwd, 1);
    checkOutput("bwd_pass_m_data", m_data_bwd, 16'h000A);
    checkOutput("bwd_pass_s_ready", s_ready_bwd, 1);
    tick();
    s_data_bwd = 16'h000B;
    #1;
    checkOutput("bwd_skid_s_ready", s_ready_bwd, 0);
    checkOutput("bwd_skid_m_valid", m_valid_bwd, 1);
    checkOutput("bwd_skid_m_data", m_data_bwd, 16'h000A);
    checkOutput("bwd_skid_occ", occ_bwd, 1);
    checkOutput("bwd_skid_af", af_bwd, 1);
    m_ready_bwd = 1'b1;
    #1;
    checkOutput("bwd_skid_hold_data", m_data_bwd, 16'h000A);
    tick();
    checkOutput("bwd_freed_s_ready", s_ready_bwd, 1);
    checkOutput("bwd_next_m_data", m_data_bwd, 16'h000B);
    checkOutput("bwd_freed_occ", occ_bwd, 0);
    tick();
    s_valid_bwd = 1'b0;
    #1;
    checkOutput("bwd_idle_m_valid", m_valid_bwd, 0);

    // FIFO depth 3: fill with 1,2,3 while downstream stalls.
    m_ready_fifo = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      s_valid_fifo = 1'b1;
      s_data_fifo  = DW'(k);
      tick();
      checkOutput($sformatf("fifo_fill_occ[%0d]", k), occ_fifo, 64'(k));
      checkOutput($sformatf("fifo_fill_af[%0d]", k), af_fifo, 64'(k >= 2));
      checkOutput($sformatf("fifo_fill_s_ready[%0d]", k), s_ready_fifo, 64'(k < 3));
      checkOutput($sformatf("fifo_fill_m_data[%0d]", k), m_data_fifo, 1);
    end
    // Full: a dequeue does not open a slot in the same cycle.
    s_data_fifo  = 16'd4;
    m_ready_fifo = 1'b1;
    #1;
    checkOutput("fifo_full_s_ready", s_ready_fifo, 0);
    checkOutput("fifo_full_m_valid", m_valid_fifo, 1);
    tick();
    // Steady stream through wrapping pointers: output lags input by two.
    for (int j = 0; j < 8; j++) begin
      s_data_fifo = DW'(4 + j);
      #1;
      checkOutput($sformatf("fifo_stream_m_data[%0d]", j), m_data_fifo, 64'(2 + j));
      checkOutput($sformatf("fifo_stream_s_ready[%0d]", j), s_ready_fifo, 1);
      checkOutput($sformatf("fifo_stream_occ[%0d]", j), occ_fifo, 2);
      tick();
    end

    // Flush with both sides willing: nothing moves, then empty.
    s_data_fifo = 16'h0099;
    flush = 1'b1;
    #1;
    checkOutput("fifo_flush_m_valid", m_valid_fifo, 0);
    checkOutput("fifo_flush_s_ready", s_ready_fifo, 0);
    tick();
    flush = 1'b0;
    s_valid_fifo = 1'b0;
    #1;
    checkOutput("fifo_post_flush_occ", occ_fifo, 0);
    checkOutput("fifo_post_flush_m_valid", m_valid_fifo, 0);
    checkOutput("fifo_post_flush_af", af_fifo, 0);

    // Load every stateful instance, then reset mid-stream.
    m_ready_fifo = 1'b0;
    s_valid_fifo = 1'b1; s_data_fifo = 16'h0042;
    s_valid_fwd  = 1'b1; s_data_fwd  = 16'h0033; m_ready_fwd = 1'b0;
    s_valid_bwd  = 1'b1; s_data_bwd  = 16'h0044; m_ready_bwd = 1'b0;
    tick();
    s_valid_fifo = 1'b0; s_valid_fwd = 1'b0; s_valid_bwd = 1'b0;
    #1;
    checkOutput("pre_rst_fifo_m_data", m_data_fifo, 16'h0042);
    checkOutput("pre_rst_occ_fifo", occ_fifo, 1);
    checkOutput("pre_rst_occ_fwd", occ_fwd, 1);
    checkOutput("pre_rst_occ_bwd", occ_bwd, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_s_ready_fwd", s_ready_fwd, 0);
    checkOutput("mid_rst_s_ready_bwd", s_ready_bwd, 0);
    checkOutput("mid_rst_s_ready_fifo", s_ready_fifo, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("after_rst_m_valid_fwd", m_valid_fwd, 0);
    checkOutput("after_rst_m_valid_bwd", m_valid_bwd, 0);
    checkOutput("after_rst_m_valid_fifo", m_valid_fifo, 0);
    checkOutput("after_rst_occ_fwd", occ_fwd, 0);
    checkOutput("after_rst_occ_bwd", occ_bwd, 0);
    checkOutput("after_rst_occ_fifo", occ_fifo, 0);
    checkOutput("after_rst_af_fifo", af_fifo, 0);
    checkOutput("after_rst_af_bwd", af_bwd, 0);
    checkOutput("after_rst_m_data_fwd", m_data_fwd, 0);
    checkOutput("after_rst_m_data_fifo", m_data_fifo, 0);

    // Stream restarts cleanly after reset.
    s_valid_fifo = 1'b1;
    s_data_fifo  = 16'h0055;
    m_ready_fifo = 1'b1;
    tick();
    s_valid_fifo = 1'b0;
    #1;
    checkOutput("restart_m_valid", m_valid_fifo, 1);
    checkOutput("restart_m_data", m_data_fifo, 16'h0055);
    tick();
    checkOutput("restart_drained_m_valid", m_valid_fifo, 0);
    checkOutput("restart_drained_occ", occ_fifo, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
